down_count_ctrl: RTL and testbench
==================================

Name: down_count_ctrl

Overview:
Sequencing controller for a loadable down counter used as a programmable timer. It captures a start value, prescale divisor and mode on a start command. It then decrements through a prescaler, pulses `expire` on terminal count, and either stops (one-shot) or reloads (periodic). Pause and stop commands are supported. It sits between the control/register logic and any consumer that needs timed events.

Parameters:
- WIDTH, 4, counter width in bits; legal load range 1 .. 2^WIDTH-1.
- PWIDTH, 4, prescale field width; a decrement step occurs every prescale+1 clocks.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a count from IDLE or DONE (single-cycle strobe; the level is sampled).
- stop  input  1  abort and return to IDLE.
- pause  input  1  level; while high in RUN/PAUSE, the count is frozen.
- periodic  input  1  mode, captured at start: 1 = auto-reload, 0 = one-shot.
- load_val  input  WIDTH  start value, captured at start.
- prescale  input  PWIDTH  divisor minus one, captured at start.
- count  output  WIDTH  current counter value.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE (level).
- expire  output  1  one-cycle pulse on terminal count.
- err  output  1  one-cycle pulse when start is rejected.
- state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (asynchronous): state=IDLE, count=0, busy=0, done=0, expire=0, err=0.
  - Internal registers clear: prescale counter, reload register, prescale register, mode register.
- All outputs are registered.
- Command priority in every state: stop > pause > start.
- IDLE or DONE, start=1, load_val != 0:
  - Capture load_val, prescale and periodic.
  - On the same edge: count=load_val, prescale counter=0, state=RUN.
- IDLE or DONE, start=1, load_val == 0:
  - err=1 for one cycle.
  - State and count are unchanged.
- RUN:
  - The prescale counter increments each clock.
  - When it equals the captured prescale, it wraps to 0 and a step occurs.
  - First decrement: prescale+1 clocks after the start edge.
- Step with count > 1: count = count-1.
- Step with count == 1, one-shot: count=0, state=DONE, expire=1 on the same edge.
- Step with count == 1, periodic: count=reload value, state stays RUN, expire=1.
  - Expire period = load_val × (prescale+1) clocks.
- start while in RUN or PAUSE: ignored. No err, no reload.
- pause=1 in RUN: state=PAUSE on the next edge.
  - count and prescale counter freeze; no step occurs on that edge.
- PAUSE with pause=0: return to RUN.
  - Counting resumes from the frozen prescale counter value.
- stop=1 in any state: next edge gives state=IDLE, count=0, prescale counter=0, expire=0.
  - stop on the same edge as a terminal step suppresses expire.
- DONE: holds count=0 and done=1 until start (restart with new capture) or stop.
- busy = (state==RUN || state==PAUSE); done = (state==DONE). Both are registered.
- Count never wraps below 0. Periodic mode reloads from the captured value, not from live load_val.
- Reset mid-operation returns immediately to the reset values. No pending expire is produced.

Decomposition:
- Package down_count_ctrl_pkg:
  - State encoding localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - 2-bit state typedef.
  - Default WIDTH/PWIDTH constants.
- One sub-module, down_count_prescaler:
  - Inputs: clk, rst, clear, enable, divisor.
  - Output: step pulse.
  - It holds the prescale counter and wrap compare.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Reset then one-shot: load_val=3, prescale=0, start → count 3,2,1,0 on consecutive edges; expire=1 exactly on the 1→0 edge; done=1 afterwards; busy=0.
- Periodic with prescale: load_val=2, prescale=1, periodic=1 → count sequence 2,2,1,1,2,… and expire pulses every 4 clocks for 3 periods; busy stays 1.
- Pause: load_val=5, prescale=0, pause high 3 cycles after count=3 → count holds 3 for 3 cycles, then 2,1,0; total start-to-expire = 8 clocks.
- Command priority: stop and start together in DONE → IDLE, count=0; stop on the terminal edge → no expire pulse; start while RUN → sequence unaffected.
- Rejection and restart: start with load_val=0 in IDLE → err pulse, state stays 0; then start with load_val=15 from DONE → count=15, state=RUN.
- Async reset mid-count: assert rst between clock edges at count=2 → all outputs return to reset values immediately, without waiting for a clock edge; after release, IDLE persists until start.

Source files
------------

// File: rtl/down_count_ctrl_pkg.sv
// down_count_ctrl_pkg: shared state encoding and default widths for the down-count timer controller.
package down_count_ctrl_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PWIDTH = 4;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/down_count_prescaler.sv
// down_count_prescaler: free-running divide-by-(divisor+1) counter emitting a step pulse on wrap.
module down_count_prescaler #(
  parameter int PWIDTH = down_count_ctrl_pkg::DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [PWIDTH-1:0] divisor,
  output logic              step
);
  logic [PWIDTH-1:0] cnt_q, cnt_d;
  logic wrap;
  always_comb begin
    wrap  = cnt_q == divisor;
    step  = enable && wrap;
    cnt_d = clear ? '0 : !enable ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/down_count_ctrl.sv
// down_count_ctrl: loadable prescaled down-counter timer with one-shot/periodic modes, pause and stop.
module down_count_ctrl
  import down_count_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              periodic,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [PWIDTH-1:0] prescale,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              expire,
  output logic              err,
  output logic [1:0]        state
);
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d, reload_q, reload_d;
  logic [PWIDTH-1:0] presc_q, presc_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              expire_q, expire_d, err_q, err_d;
  logic              active, launch, accept, reject, enable, step, terminal;
  // Pause outranks start, so a held pause also blocks launching from IDLE/DONE.
  always_comb begin
    active   = state_q == ST_RUN || state_q == ST_PAUSE;
    launch   = !active && !stop && !pause && start;
    accept   = launch && load_val != '0;
    reject   = launch && load_val == '0;
    enable   = active && !stop && !pause;
    terminal = step && count_q == WIDTH'(1);
  end
  down_count_prescaler #(.PWIDTH(PWIDTH)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (stop || accept),
    .enable  (enable),
    .divisor (presc_q),
    .step    (step)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = stop                 ? ST_IDLE  :
              accept               ? ST_RUN   :
              !active              ? state_q  :
              pause                ? ST_PAUSE :
              terminal && !mode_q  ? ST_DONE  : ST_RUN;
  always_comb begin
    count_d  = stop    ? '0 :
               accept  ? load_val :
               !step   ? count_q :
               terminal ? (mode_q ? reload_q : '0) : count_q - 1'b1;
    reload_d = accept ? load_val : reload_q;
    presc_d  = accept ? prescale : presc_q;
    mode_d   = accept ? periodic : mode_q;
    busy_d   = state_d == ST_RUN || state_d == ST_PAUSE;
    done_d   = state_d == ST_DONE;
    expire_d = terminal;
    err_d    = reject;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  assign count  = count_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign expire = expire_q;
  assign err    = err_q;
  assign state  = state_q;
endmodule

// File: tb/tb_down_count_ctrl.sv
// tb_down_count_ctrl: directed plus randomized checking of down_count_ctrl against a behavioural timer model.
module tb_down_count_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
  logic [3:0] load_val = '0, prescale = '0;
  logic [3:0] count;
  logic       busy, done, expire, err;
  logic [1:0] state;
  int n_tests = 0, n_fail = 0;
  int mst, mcnt, mleft, mrel, mpre, mper, mexp, merr;
  down_count_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .load_val(load_val), .prescale(prescale),
    .count(count), .busy(busy), .done(done), .expire(expire), .err(err), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Model tracks clocks-until-next-step rather than a prescale phase counter.
  task automatic model_reset();
    mst = 0; mcnt = 0; mleft = 0; mrel = 0; mpre = 0; mper = 0; mexp = 0; merr = 0;
  endtask
  task automatic model_edge();
    mexp = 0; merr = 0;
    if (stop) begin
      mst = 0; mcnt = 0;
    end else if (mst == 1 || mst == 2) begin
      if (pause) mst = 2;
      else begin
        mst = 1;
        mleft = mleft - 1;
        if (mleft == 0) begin
          mleft = mpre + 1;
          if (mcnt > 1) mcnt = mcnt - 1;
          else begin
            mexp = 1;
            if (mper != 0) mcnt = mrel;
            else begin mcnt = 0; mst = 3; end
          end
        end
      end
    end else if (start && !pause) begin
      if (load_val == 0) merr = 1;
      else begin
        mrel = load_val; mpre = prescale; mper = periodic;
        mcnt = load_val; mleft = prescale + 1; mst = 1;
      end
    end
  endtask
  task automatic compare();
    check("count", count, mcnt);
    check("state", state, mst);
    check("busy", busy, (mst == 1 || mst == 2) ? 1 : 0);
    check("done", done, mst == 3 ? 1 : 0);
    check("expire", expire, mexp);
    check("err", err, merr);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  task automatic drive(input logic s, input logic sp, input logic pa, input logic per,
                       input int lv, input int ps);
    start = s; stop = sp; pause = pa; periodic = per;
    load_val = 4'(lv); prescale = 4'(ps);
  endtask
  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
    tick();
    // one-shot 3,2,1,0
    drive(1, 0, 0, 0, 3, 0); tick();
    idle_in(); repeat (5) tick();
    // periodic, prescale 1, three periods
    drive(1, 0, 0, 1, 2, 1); tick();
    idle_in(); repeat (12) tick();
    drive(1, 0, 0, 0, 9, 0); repeat (3) tick();
    idle_in(); repeat (2) tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    // pause mid-count
    drive(1, 0, 0, 0, 5, 0); tick();
    idle_in(); repeat (2) tick();
    pause = 1'b1; repeat (3) tick();
    pause = 1'b0; repeat (5) tick();
    // stop together with start in DONE
    drive(1, 1, 0, 0, 7, 0); tick();
    check("prio_state", state, 0);
    idle_in(); tick();
    // stop on the terminal edge
    drive(1, 0, 0, 0, 2, 0); tick();
    idle_in(); tick();
    stop = 1'b1; tick();
    check("stop_noexp", expire, 0);
    idle_in(); tick();
    // rejected start, then restart from DONE
    drive(1, 0, 0, 0, 0, 2); tick();
    check("reject_err", err, 1);
    drive(1, 0, 0, 0, 1, 0); tick();
    idle_in(); repeat (2) tick();
    drive(1, 0, 0, 0, 15, 3); tick();
    check("restart_cnt", count, 15);
    idle_in(); repeat (10) tick();
    // async reset between edges
    while (count != 2) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    #2 rst = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
